serial_byte_assembler: RTL and testbench
========================================

// Module: serial_byte_assembler
// PURPOSE
//   Collects a serial bit stream into WIDTH-bit parallel words and feeds the downstream bit-order
//   stage (8-bit din -> dout reversal). Bit arrival order is selectable. Valid/ready on both sides;
//   a one-word pending buffer absorbs downstream stalls. Frame alignment input discards partial words.
// PARAMETERS
//   WIDTH      8   bits per assembled word
//   LSB_FIRST  1   1: first received bit -> dout[0]; 0: first received bit -> dout[WIDTH-1]
//   COUNT_W    16  width of the delivered-word counter
// PORTS
//   clk           in   1        clock, all state on rising edge
//   rst_n         in   1        asynchronous, active-low reset
//   bit_in        in   1        serial data bit
//   bit_valid     in   1        bit_in is valid this cycle
//   bit_ready     out  1        block can accept a bit this cycle
//   align         in   1        sync pulse: discard partial word, restart at bit 0
//   dout          out  WIDTH    assembled word (to bit-order stage din)
//   dout_valid    out  1        dout holds a word
//   dout_ready    in   1        downstream accepts dout
//   partial_drop  out  1        one-cycle pulse: align discarded >=1 collected bit
//   word_count    out  COUNT_W  number of dout handshakes since reset, wraps
// BEHAVIOUR
//   - Reset (async, rst_n=0): shift reg, bit counter, pending flag, dout, dout_valid, partial_drop,
//     word_count all 0; bit_ready=1. Outputs change immediately on assertion, not on clk.
//   - Bit accept = bit_valid & bit_ready. Bit k of a word (k=0 first) lands at position k
//     (LSB_FIRST=1) or WIDTH-1-k (LSB_FIRST=0). Bit counter range 0..WIDTH-1.
//   - On the WIDTH-th accepted bit: if output slot free (!dout_valid | dout_ready) the word loads
//     into dout and dout_valid=1 on the next edge (latency 1 cycle after last bit); counter -> 0.
//     Else the word is held as pending, counter -> 0, bit_ready=0 from the next cycle.
//   - Pending: when dout_valid & dout_ready, pending word loads into dout next edge, dout_valid stays 1,
//     pending clears, bit_ready=1 next cycle. Pending word and dout never both lost or duplicated.
//   - dout_valid=1 & dout_ready=0: dout held stable. dout_valid drops only after handshake with
//     no new word to load.
//   - Throughput with dout_ready=1: one word per WIDTH accepted bits, no bubbles.
//   - align has priority over bit accept: same-cycle bit is discarded; shift reg and counter clear;
//     partial_drop=1 next cycle iff counter was nonzero. align never affects dout or pending word.
//   - word_count += 1 on each dout_valid & dout_ready; wraps 2^COUNT_W-1 -> 0.
//   - bit_ready = !pending (combinational from register); no dependency on bit_valid.
// STRUCTURE
//   - Package serial_asm_pkg: default WIDTH/COUNT_W localparams, bit-counter width function
//     ($clog2(WIDTH)).
//   - Sub-module assembler_out_slot: dout register + pending register + handshake logic;
//     top holds shift register, bit counter, align/partial_drop, word_count.
// TESTING
//   1. LSB_FIRST=1, dout_ready=1, bits 1,0,0,0,0,0,0,0 -> dout=8'h01, dout_valid one cycle after
//      8th bit, word_count=1.
//   2. LSB_FIRST=0, same bits -> dout=8'h80; back-to-back 16 bits -> two words, no bubble.
//   3. dout_ready=0, send words 8'hA5 then 8'h3C -> dout=A5 held, bit_ready=0 after 16th bit;
//      raise dout_ready one cycle -> next cycle dout=3C, bit_ready=1, word_count=1.
//   4. 3 bits then align (with bit_valid=1 same cycle) -> partial_drop pulse 1 cycle; next 8 bits
//      0xF0 -> dout=F0. align with counter 0 -> no pulse.
//   5. rst_n low mid-word with dout_valid=1 and pending set -> all outputs 0, bit_ready=1 immediately.
//   6. COUNT_W=4, 17 handshakes -> word_count wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/serial_byte_assembler_pkg.sv
// Shared defaults, output-slot state encoding and sizing helper for the serial byte assembler.
package serial_asm_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_COUNT_W = 16;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_FULL,
        SLOT_BOTH
    } slot_state_e;

    function automatic int unsigned bit_cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_byte_assembler_if.sv
// Serial input stream, align pulse and parallel output stream of the serial byte assembler.
interface serial_byte_assembler_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
);
    logic               bit_in;
    logic               bit_valid;
    logic               bit_ready;
    logic               align;
    logic [WIDTH-1:0]   dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               partial_drop;
    logic [COUNT_W-1:0] word_count;

    modport master (
        output bit_in, bit_valid, align, dout_ready,
        input  bit_ready, dout, dout_valid, partial_drop, word_count
    );

    modport slave (
        input  bit_in, bit_valid, align, dout_ready,
        output bit_ready, dout, dout_valid, partial_drop, word_count
    );
endinterface

// File: rtl/serial_byte_assembler_out_slot.sv
// Output register plus one-word pending buffer; absorbs a single downstream stall.
module assembler_out_slot
    import serial_asm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_load,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             pending,
    output logic             handshake
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] dout_q, pend_q, dout_d;
    logic             load_dout, load_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            dout_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_dout) dout_q <= dout_d;
            if (load_pend) pend_q <= word_in;
        end
    end

    // word_load never arrives in SLOT_BOTH: the assembler stalls bit intake while pending
    always_comb begin
        state_d   = state_q;
        load_dout = 1'b0;
        load_pend = 1'b0;
        dout_d    = word_in;
        case (state_q)
            SLOT_EMPTY: begin
                if (word_load) begin
                    state_d   = SLOT_FULL;
                    load_dout = 1'b1;
                end
            end
            SLOT_FULL: begin
                if (word_load) begin
                    if (dout_ready) begin
                        load_dout = 1'b1;
                    end else begin
                        load_pend = 1'b1;
                        state_d   = SLOT_BOTH;
                    end
                end else if (dout_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_BOTH: begin
                if (dout_ready) begin
                    state_d   = SLOT_FULL;
                    load_dout = 1'b1;
                    dout_d    = pend_q;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q != SLOT_EMPTY);
    assign pending    = (state_q == SLOT_BOTH);
    assign handshake  = dout_valid & dout_ready;

endmodule

// File: rtl/serial_byte_assembler.sv
// Serial-to-parallel word assembler with selectable bit order, frame align and delivered-word count.
module serial_byte_assembler
    import serial_asm_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned COUNT_W   = DEFAULT_COUNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_byte_assembler_if.slave  bus
);

    localparam int unsigned CNT_W = bit_cnt_w(WIDTH);

    logic [WIDTH-1:0]   shift_q, word_next;
    logic [CNT_W-1:0]   cnt_q, pos;
    logic [COUNT_W-1:0] word_count_q;
    logic               partial_drop_q;
    logic               pending, handshake, accept, last_bit;

    assign bus.bit_ready = !pending;
    assign accept        = bus.bit_valid & !pending & !bus.align;
    assign last_bit      = accept && (cnt_q == CNT_W'(WIDTH - 1));

    // word_next includes the bit arriving this cycle so the final bit reaches dout without extra delay
    always_comb begin
        pos            = LSB_FIRST ? cnt_q : (CNT_W'(WIDTH - 1) - cnt_q);
        word_next      = shift_q;
        word_next[pos] = bus.bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q        <= '0;
            cnt_q          <= '0;
            partial_drop_q <= 1'b0;
        end else if (bus.align) begin
            shift_q        <= '0;
            cnt_q          <= '0;
            partial_drop_q <= (cnt_q != '0);
        end else begin
            partial_drop_q <= 1'b0;
            if (last_bit) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (accept) begin
                shift_q <= word_next;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         word_count_q <= '0;
        else if (handshake) word_count_q <= word_count_q + COUNT_W'(1);
    end

    assembler_out_slot #(.WIDTH(WIDTH)) u_out_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_next),
        .word_load  (last_bit),
        .dout_ready (bus.dout_ready),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .pending    (pending),
        .handshake  (handshake)
    );

    assign bus.partial_drop = partial_drop_q;
    assign bus.word_count   = word_count_q;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Drives an LSB-first (4-bit counter) and an MSB-first (16-bit counter) assembler with identical stimulus.
module tb_serial_byte_assembler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_byte_assembler_if #(.WIDTH(8), .COUNT_W(4))  ifl ();
    serial_byte_assembler_if #(.WIDTH(8), .COUNT_W(16)) ifm ();

    serial_byte_assembler #(.WIDTH(8), .LSB_FIRST(1'b1), .COUNT_W(4)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(ifl.slave)
    );
    serial_byte_assembler #(.WIDTH(8), .LSB_FIRST(1'b0), .COUNT_W(16)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(ifm.slave)
    );

    // Reference: collected bits in arrival order, output words (arrival-order byte) queued oldest first
    bit         m_bits[$];
    logic [7:0] m_outq[$];
    int         m_count;
    bit         m_pd;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic void model_reset();
        m_bits.delete();
        m_outq.delete();
        m_count = 0;
        m_pd    = 1'b0;
    endfunction

    function automatic void model_edge(input bit bv, input bit b, input bit al, input bit rdy);
        bit         room;
        logic [7:0] w;
        room = (m_outq.size() < 2);
        if (m_outq.size() > 0 && rdy) begin
            void'(m_outq.pop_front());
            m_count++;
        end
        m_pd = 1'b0;
        if (al) begin
            m_pd = (m_bits.size() != 0);
            m_bits.delete();
        end else if (bv && room) begin
            m_bits.push_back(b);
            if (m_bits.size() == 8) begin
                for (int k = 0; k < 8; k++) w[k] = m_bits[k];
                m_outq.push_back(w);
                m_bits.delete();
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("l_valid", 32'(ifl.dout_valid), 32'(m_outq.size() > 0));
        chk("m_valid", 32'(ifm.dout_valid), 32'(m_outq.size() > 0));
        chk("l_ready", 32'(ifl.bit_ready), 32'(m_outq.size() < 2));
        chk("m_ready", 32'(ifm.bit_ready), 32'(m_outq.size() < 2));
        chk("l_pdrop", 32'(ifl.partial_drop), 32'(m_pd));
        chk("m_pdrop", 32'(ifm.partial_drop), 32'(m_pd));
        chk("l_count", 32'(ifl.word_count), 32'(m_count % 16));
        chk("m_count", 32'(ifm.word_count), 32'(m_count % 65536));
        if (m_outq.size() > 0) begin
            chk("l_dout", 32'(ifl.dout), 32'(m_outq[0]));
            chk("m_dout", 32'(ifm.dout), 32'(rev8(m_outq[0])));
        end
    endtask

    task automatic drive(input bit bv, input bit b, input bit al, input bit rdy);
        ifl.bit_valid = bv;  ifm.bit_valid = bv;
        ifl.bit_in    = b;   ifm.bit_in    = b;
        ifl.align     = al;  ifm.align     = al;
        ifl.dout_ready = rdy; ifm.dout_ready = rdy;
    endtask

    task automatic step(input bit bv, input bit b, input bit al, input bit rdy);
        drive(bv, b, al, rdy);
        model_edge(bv, b, al, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] v, input bit rdy);
        for (int k = 0; k < 8; k++) step(1'b1, v[k], 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_l_dout", 32'(ifl.dout), 32'h0);
        chk("rst_m_dout", 32'(ifm.dout), 32'h0);
        check_all();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        do_reset();

        // Bit order: 1 then seven 0s
        for (int k = 0; k < 7; k++) step(1'b1, (k == 0), 1'b0, 1'b1);
        chk("t1_not_yet", 32'(ifl.dout_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t1_l_dout", 32'(ifl.dout), 32'h01);
        chk("t2_m_dout", 32'(ifm.dout), 32'h80);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_count", 32'(ifl.word_count), 32'h1);

        // Back-to-back words, no bubble
        send_byte(8'h5A, 1'b1);
        chk("t2_first", 32'(ifl.dout), 32'h5A);
        send_byte(8'hC3, 1'b1);
        chk("t2_second", 32'(ifl.dout), 32'hC3);
        chk("t2_count", 32'(ifm.word_count), 32'h2);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Stall: A5 held in dout, 3C pending
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        chk("t3_held", 32'(ifl.dout), 32'hA5);
        chk("t3_stall", 32'(ifl.bit_ready), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3_next", 32'(ifl.dout), 32'h3C);
        chk("t3_ready", 32'(ifl.bit_ready), 32'h1);
        chk("t3_count", 32'(ifl.word_count), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Align mid-word, then a clean word, then align on a word boundary
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_pulse", 32'(ifl.partial_drop), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_pulse_end", 32'(ifl.partial_drop), 32'h0);
        send_byte(8'hF0, 1'b1);
        chk("t4_l_dout", 32'(ifl.dout), 32'hF0);
        chk("t4_m_dout", 32'(ifm.dout), 32'h0F);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_no_pulse", 32'(ifl.partial_drop), 32'h0);

        // Asynchronous reset with dout valid and a pending word
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_pending", 32'(ifm.bit_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_valid", 32'(ifm.dout_valid), 32'h0);
        chk("t5_ready", 32'(ifm.bit_ready), 32'h1);
        chk("t5_dout", 32'(ifm.dout), 32'h0);
        chk("t5_count", 32'(ifm.word_count), 32'h0);
        do_reset();

        // Counter wrap on the 4-bit instance
        for (int n = 0; n < 16; n++) send_byte(8'(n * 7 + 1), 1'b1);
        chk("t6_at15", 32'(ifl.word_count), 32'd15);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_wrap0", 32'(ifl.word_count), 32'd0);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_wrap1", 32'(ifl.word_count), 32'd1);
        chk("t6_m_count", 32'(ifm.word_count), 32'd17);

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
